// File: rtl/vga_sync_gen.sv
// Purpose: VGA raster timing (pixel clock, hs/vs/blank, DrawX/DrawY, frame_start) from the system clock.
// Latency: DrawX/DrawY/frame_start registered on the pixel tick; hs/vs/blank lag them by SYNC_DELAY ticks.
// Backpressure: none; free-running source, downstream consumers must keep up every pixel.
module vga_sync_gen #(
    parameter int CLK_DIV    = 2,
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    output logic       pixel_clk,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       sync,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);

    logic [DIV_W-1:0] div;
    logic             pe;
    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;

    // Stage 0 holds the raw timing, stage SYNC_DELAY drives the outputs.
    logic [SYNC_DELAY:0] hs_p;
    logic [SYNC_DELAY:0] vs_p;
    logic [SYNC_DELAY:0] blank_p;

    assign pe        = (div == DIV_W'(CLK_DIV - 1));
    assign pixel_clk = (div >= DIV_W'(CLK_DIV / 2));
    assign sync      = 1'b0;
    assign hs        = hs_p[SYNC_DELAY];
    assign vs        = vs_p[SYNC_DELAY];
    assign blank     = blank_p[SYNC_DELAY];

    // Clock divider producing the one-cycle pixel enable.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div <= '0;
        end else if (pe) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Next raster position; raw timing is decoded from it so outputs align with DrawX/DrawY.
    always_comb begin
        x_nxt = DrawX + 10'd1;
        y_nxt = DrawY;
        if (DrawX == H_LAST) begin
            x_nxt = 10'd0;
            y_nxt = (DrawY == V_LAST) ? 10'd0 : DrawY + 10'd1;
        end
    end

    // Raster counters and the frame strobe (strobe cleared on every non-tick edge).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            DrawX       <= '0;
            DrawY       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pe && (x_nxt == 10'd0) && (y_nxt == V_VIS);
            if (pe) begin
                DrawX <= x_nxt;
                DrawY <= y_nxt;
            end
        end
    end

    // Raw sync/blank decode plus the optional pixel-tick delay line.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hs_p    <= '1;
            vs_p    <= '1;
            blank_p <= '0;
        end else if (pe) begin
            hs_p[0]    <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
            vs_p[0]    <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
            blank_p[0] <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            for (int i = 1; i <= SYNC_DELAY; i++) begin
                hs_p[i]    <= hs_p[i-1];
                vs_p[i]    <= vs_p[i-1];
                blank_p[i] <= blank_p[i-1];
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Purpose: checks full-size row timing against a vector table and a shrunk, delayed-sync
// instance cycle by cycle against a reference model through an expected-value queue.
// Also covers reset values, async mid-frame reset, frame_start spacing and sync delay.
module tb_vga_sync_gen;

    // Shrunk raster for the model-checked instance: H_TOTAL=24, V_TOTAL=15.
    localparam int BH_VIS = 16, BH_FP = 2, BH_SW = 3, BH_BP = 3;
    localparam int BV_VIS = 8,  BV_FP = 2, BV_SW = 2, BV_BP = 3;
    localparam int BH_TOT = BH_VIS + BH_FP + BH_SW + BH_BP;
    localparam int BV_TOT = BV_VIS + BV_FP + BV_SW + BV_BP;
    localparam int PHASE_EDGES = 1700;

    typedef struct packed {
        logic       pclk;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       sync;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } obs_t;

    typedef struct {
        int   n;
        obs_t exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       a_pclk, a_hs, a_vs, a_blank, a_sync, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_pclk, b_hs, b_vs, b_blank, b_sync, b_fs;
    logic [9:0] b_x, b_y;

    int errors;
    int checks;

    vga_sync_gen dut_a (
        .Clk(clk), .Reset_n(rst_n), .pixel_clk(a_pclk), .hs(a_hs), .vs(a_vs),
        .blank(a_blank), .sync(a_sync), .DrawX(a_x), .DrawY(a_y), .frame_start(a_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(2),
        .H_VISIBLE(BH_VIS), .H_FRONT(BH_FP), .H_SYNC(BH_SW), .H_BACK(BH_BP),
        .V_VISIBLE(BV_VIS), .V_FRONT(BV_FP), .V_SYNC(BV_SW), .V_BACK(BV_BP),
        .SYNC_DELAY(2)
    ) dut_b (
        .Clk(clk), .Reset_n(rst_n), .pixel_clk(b_pclk), .hs(b_hs), .vs(b_vs),
        .blank(b_blank), .sync(b_sync), .DrawX(b_x), .DrawY(b_y), .frame_start(b_fs)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic obs_t mk(logic pclk, logic hs, logic vs, logic blank, logic fs,
                                int x, int y);
        obs_t o;
        o.pclk = pclk; o.hs = hs; o.vs = vs; o.blank = blank; o.sync = 1'b0; o.fs = fs;
        o.x = 10'(x); o.y = 10'(y);
        return o;
    endfunction

    function automatic obs_t obs_a();
        return mk(a_pclk, a_hs, a_vs, a_blank, a_fs, int'(a_x), int'(a_y)) | {4'b0, a_sync, 21'b0};
    endfunction

    function automatic obs_t obs_b();
        return mk(b_pclk, b_hs, b_vs, b_blank, b_fs, int'(b_x), int'(b_y)) | {4'b0, b_sync, 21'b0};
    endfunction

    task automatic chk(input string name, input int n, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got=%h required=%h", name, n, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    // Reference model of the shrunk instance.
    int     m_div, m_x, m_y;
    logic   m_fs;
    logic [2:0] m_hist [0:2];   // {hs, vs, blank}; [0] raw, [2] visible at outputs
    obs_t   sbq [$];

    task automatic model_reset();
        m_div = 0; m_x = 0; m_y = 0; m_fs = 1'b0;
        for (int i = 0; i < 3; i++) m_hist[i] = 3'b110;
        sbq.delete();
    endtask

    task automatic model_step();
        logic hs_raw, vs_raw, bl_raw;
        m_fs = 1'b0;
        if (m_div == 1) begin
            m_x = m_x + 1;
            if (m_x == BH_TOT) begin
                m_x = 0;
                m_y = (m_y + 1) % BV_TOT;
            end
            hs_raw = !(m_x >= BH_VIS + BH_FP && m_x < BH_VIS + BH_FP + BH_SW);
            vs_raw = !(m_y >= BV_VIS + BV_FP && m_y < BV_VIS + BV_FP + BV_SW);
            bl_raw = (m_x < BH_VIS) && (m_y < BV_VIS);
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = {hs_raw, vs_raw, bl_raw};
            m_fs = (m_x == 0) && (m_y == BV_VIS);
        end
        m_div = (m_div + 1) % 2;
        sbq.push_back(mk(m_div == 1, m_hist[2][2], m_hist[2][1], m_hist[2][0], m_fs, m_x, m_y));
    endtask

    vec_t tbl [12];
    int   fs_count, fs_last, fs_gap, a_fs_seen;
    int   cyc_x, cyc_h;
    logic prev_hs;
    logic [9:0] prev_x;

    // Runs one post-reset phase: scoreboard every edge for dut_b, vector table for dut_a.
    task automatic run_phase();
        obs_t exp;
        int   ti;
        ti = 0;
        fs_count = 0; fs_last = 0; fs_gap = -1; a_fs_seen = 0;
        cyc_x = -1; cyc_h = -1; prev_hs = 1'b1; prev_x = 10'd0;
        for (int n = 1; n <= PHASE_EDGES; n++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_empty n=%0d got=0 required=1", n);
            end else begin
                exp = sbq.pop_front();
                chk("sb_small", n, obs_b(), exp);
            end
            if (ti < 12 && tbl[ti].n == n) begin
                chk("vec_row", n, obs_a(), tbl[ti].exp);
                ti++;
            end
            if (a_fs) a_fs_seen++;
            if (b_fs) begin
                if (fs_count == 1) fs_gap = n - fs_last;
                fs_last = n;
                fs_count++;
            end
            if (cyc_x < 0 && b_x == 10'(BH_VIS + BH_FP) && prev_x != b_x) cyc_x = n;
            if (cyc_h < 0 && prev_hs && !b_hs) cyc_h = n;
            prev_x  = b_x;
            prev_hs = b_hs;
        end
        chk_int("vec_table_done", ti, 12);
        chk_int("fs_count_2frames", fs_count, 2);
        chk_int("fs_gap_clk", fs_gap, 2 * BH_TOT * BV_TOT);
        chk_int("fs_first_clk", fs_last - fs_gap, 2 * BH_TOT * BV_VIS);
        chk_int("hs_delay_clk", cyc_h - cyc_x, 4);
        chk_int("big_fs_absent", a_fs_seen, 0);
    endtask

    initial begin
        obs_t rst_obs;
        errors = 0;
        checks = 0;
        rst_obs = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

        // Full-size row timing: after edge n, DrawX = n/2, pixel_clk = n odd.
        tbl[0]  = '{1,    mk(1, 1, 1, 0, 0, 0,   0)};
        tbl[1]  = '{2,    mk(0, 1, 1, 1, 0, 1,   0)};
        tbl[2]  = '{3,    mk(1, 1, 1, 1, 0, 1,   0)};
        tbl[3]  = '{1279, mk(1, 1, 1, 1, 0, 639, 0)};
        tbl[4]  = '{1280, mk(0, 1, 1, 0, 0, 640, 0)};
        tbl[5]  = '{1311, mk(1, 1, 1, 0, 0, 655, 0)};
        tbl[6]  = '{1312, mk(0, 0, 1, 0, 0, 656, 0)};
        tbl[7]  = '{1503, mk(1, 0, 1, 0, 0, 751, 0)};
        tbl[8]  = '{1504, mk(0, 1, 1, 0, 0, 752, 0)};
        tbl[9]  = '{1599, mk(1, 1, 1, 0, 0, 799, 0)};
        tbl[10] = '{1600, mk(0, 1, 1, 1, 0, 0,   1)};
        tbl[11] = '{1601, mk(1, 1, 1, 1, 0, 0,   1)};

        rst_n = 1'b0;
        model_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset_big", 0, obs_a(), rst_obs);
        chk("reset_small", 0, obs_b(), rst_obs);
        rst_n = 1'b1;
        run_phase();

        // Async reset asserted mid-pixel, well away from any clock edge.
        #3;
        chk_int("pre_reset_big_nonzero", (a_x != 10'd0 || a_y != 10'd0) ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        chk("midreset_big", 0, obs_a(), rst_obs);
        chk("midreset_small", 0, obs_b(), rst_obs);
        repeat (3) @(negedge clk);
        chk("held_reset_small", 0, obs_b(), rst_obs);
        model_reset();
        rst_n = 1'b1;
        run_phase();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
